// File: rtl/load_store_unit.sv
// Load/store unit: checks alignment/range, drives a word-addressed data memory,
// and uses read-modify-write for byte and halfword stores.
module load_store_unit #(
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StWrite} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_mis_q, rsp_mis_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic        bad_type, bad_func3, bad_addr, is_fault, is_mis;
    logic [31:0] lane_byte_word;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request classification; fault outranks misalignment.
    always_comb begin
        bad_type  = (req_load == req_store);
        bad_func3 = req_load ? (req_func3 == 3'd3 || req_func3 >= 3'd6) : (req_func3 >= 3'd3);
        bad_addr  = (req_addr >= DMEM_BYTES);
        is_fault  = bad_type || bad_func3 || bad_addr;
        is_mis    = (req_func3[1:0] == 2'd1 && req_addr[0]) ||
                    (req_func3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        lane_byte_word = read_data >> {addr_q[1:0], 3'b000};
        lane_half      = addr_q[1] ? read_data[31:16] : read_data[15:0];
        case (func3_q)
            3'd0:    load_ext = {{24{lane_byte_word[7]}}, lane_byte_word[7:0]};
            3'd1:    load_ext = {{16{lane_half[15]}}, lane_half};
            3'd4:    load_ext = {24'd0, lane_byte_word[7:0]};
            3'd5:    load_ext = {16'd0, lane_half};
            default: load_ext = read_data;
        endcase
    end

    always_comb begin
        merged = read_data;
        if (func3_q[0]) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        merge_d     = merge_q;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_mis_d   = 1'b0;
        rsp_fault_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    func3_d    = req_func3;
                    mem_addr_d = {req_addr[31:2], 2'b00};
                    if (is_fault) begin
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (is_mis) begin
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else if (req_load) begin
                        state_d = StLoad;
                    end else if (req_func3[1]) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_ext;
                state_d     = StIdle;
            end
            StRmwRd: begin
                merge_d = merged;
                state_d = StWrite;
            end
            StWrite: begin
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            func3_q     <= 3'd0;
            merge_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_mis_q   <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            merge_q     <= merge_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Memory strobes gated by rst so nothing commits on a reset edge.
    always_comb begin
        req_ready      = (state_q == StIdle);
        mem_read       = !rst && (state_q == StLoad || state_q == StRmwRd);
        mem_write      = !rst && (state_q == StWrite);
        mem_addr       = mem_addr_q;
        write_data     = (state_q == StWrite) ? (func3_q[1] ? wdata_q : merge_q) : 32'd0;
        rsp_valid      = rsp_valid_q;
        rsp_rdata      = rsp_rdata_q;
        rsp_misaligned = rsp_mis_q;
        rsp_fault      = rsp_fault_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus response/write scoreboards.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misaligned, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, write_data, read_data;

    load_store_unit #(.DMEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign read_data = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= write_data;

    typedef struct {
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        bit          mis, flt;
        int          lat;
        bit          wr;
        logic [31:0] wdat;
        int          wlat;
    } vec_t;
    typedef struct { logic [31:0] rdata; bit mis, flt; int due; } rsp_t;
    typedef struct { logic [31:0] data; int due; } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];
    vec_t vecs[$];
    int   cyc = 0, checks = 0, failures = 0, rd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_misaligned", 64'(rsp_misaligned), 64'(e.mis));
                check("rsp_fault", 64'(rsp_fault), 64'(e.flt));
                check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end
        if (mem_write) begin
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("write_data", 64'(write_data), 64'(w.data));
                check("write_cycle", 64'(cyc), 64'(w.due));
            end
        end
        if (mem_read) rd_cnt++;
    end

    function automatic vec_t mk(bit ld, bit st, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, bit mis, bit flt,
                                int lat, bit wr, logic [31:0] wdat, int wlat);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.mis = mis; v.flt = flt; v.lat = lat; v.wr = wr; v.wdat = wdat; v.wlat = wlat;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input vec_t v, output int acc, output int waits);
        req_load  = v.ld;
        req_store = v.st;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=0 required=1");
            acc = -1;
        end else begin
            rsp_t r;
            acc = cyc;
            r.rdata = v.rdata; r.mis = v.mis; r.flt = v.flt; r.due = acc + v.lat;
            rq.push_back(r);
            if (v.wr) begin
                wr_t w;
                w.data = v.wdat; w.due = acc + v.wlat;
                wq.push_back(w);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drained", 64'(rq.size() + wq.size()), 64'd0);
    endtask

    initial begin
        int acc0, acc1, acc2, w0, w1, w2, rd_before;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[4] = 32'h80007F80;
        mem[8] = 32'h11223344;

        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_rsp", {29'd0, rsp_valid, rsp_misaligned, rsp_fault, rsp_rdata}, 64'd0);
        check("reset_mem", {mem_read, mem_write, mem_addr, write_data[29:0]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back(mk(1, 0, 3'd0, 32'h10, 0, 32'hFFFFFF80, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd4, 32'h10, 0, 32'h00000080, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd0, 32'h11, 0, 32'h0000007F, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd1, 32'h12, 0, 32'hFFFF8000, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd5, 32'h12, 0, 32'h00008000, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h10, 0, 32'h80007F80, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 32'h21, 32'hFFFFFFAB, 0, 0, 0, 3, 1, 32'h1122AB44, 2));
        vecs.push_back(mk(0, 1, 3'd1, 32'h22, 32'h0000BEEF, 0, 0, 0, 3, 1, 32'hBEEFAB44, 2));
        vecs.push_back(mk(1, 0, 3'd2, 32'h20, 0, 32'hBEEFAB44, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0, 32'h12345678, 0, 0, 0, 2, 1, 32'h12345678, 1));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0, 0, 32'h12345678, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd2, 32'hFFC, 0, 32'h0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 32'h23, 32'h5555, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h22, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h21, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd1, 32'h13, 0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h1000, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'd3, 32'h10, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd5, 32'h10, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3'd1, 32'h11, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            rd_before = rd_cnt;
            issue(vecs[i], acc0, w0);
            req_valid = 1'b0;
            drain();
            if (vecs[i].mis || vecs[i].flt)
                check("err_no_read", 64'(rd_cnt - rd_before), 64'd0);
        end
        check("mem_after_errors", 64'(mem[8]), 64'hBEEFAB44);
        check("mem_after_sw", 64'(mem[0]), 64'h12345678);

        // Back-to-back with req_valid held: LW, SB, LW.
        issue(mk(1, 0, 3'd2, 32'h10, 0, 32'h80007F80, 0, 0, 2, 0, 0, 0), acc0, w0);
        issue(mk(0, 1, 3'd0, 32'h21, 32'h55, 0, 0, 0, 3, 1, 32'hBEEF5544, 2), acc1, w1);
        issue(mk(1, 0, 3'd2, 32'h20, 0, 32'hBEEF5544, 0, 0, 2, 0, 0, 0), acc2, w2);
        req_valid = 1'b0;
        drain();
        check("b2b_busy_lw", 64'(w1), 64'd1);
        check("b2b_accept_sb", 64'(acc1 - acc0), 64'd2);
        check("b2b_busy_sb", 64'(w2), 64'd2);
        check("b2b_accept_lw", 64'(acc2 - acc1), 64'd3);

        // Reset during WRITE of SB 0x21: no commit, no response.
        req_load = 1'b0; req_store = 1'b1; req_func3 = 3'd0;
        req_addr = 32'h21; req_wdata = 32'hCC; req_valid = 1'b1;
        check("rst_pre_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("rst_in_write", 64'(mem_write), 64'd1);
        rst = 1'b1;
        #1 check("rst_gates_write", 64'(mem_write), 64'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_rsp", {29'd0, rsp_valid, rsp_misaligned, rsp_fault, rsp_rdata}, 64'd0);
        check("rst_mid_mem", {mem_read, mem_write, mem_addr, write_data[29:0]}, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_kept", 64'(mem[8]), 64'hBEEF5544);
        check("rst_no_pending", 64'(rq.size() + wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_memory`. It takes one load or store request per transaction and checks alignment and range. It drives the word-addressed data memory port, using read-modify-write for byte and halfword stores. It returns sign- or zero-extended load data and a completion pulse to the pipeline. Memory reads are combinational and memory writes commit on `posedge clk` while `mem_write` is high.

## Interface
- `DMEM_BYTES`, 4096: data memory size in bytes. Any address `>= DMEM_BYTES` faults.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_load` in 1: request is a load.
- `req_store` in 1: request is a store.
- `req_func3` in 3: RV32I funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data. Zero for stores and errors.
- `rsp_misaligned` out 1: alignment error, qualified by `rsp_valid`.
- `rsp_fault` out 1: range or encoding error, qualified by `rsp_valid`.
- `mem_read` out 1: to `data_memory`.
- `mem_write` out 1: to `data_memory`.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `write_data` out 32: full word to write.
- `read_data` in 32: word from `data_memory`, combinational.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `req_valid && req_ready`. On acceptance, addr, func3, wdata and type are latched.
- **Error checks on acceptance**, in priority order:
  - fault: both or neither of `req_load`/`req_store` set, illegal func3 (loads 3/6/7, stores 3–7), or `req_addr >= DMEM_BYTES`;
  - misaligned: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Either error: no memory access, state stays IDLE, response flag set next cycle. Fault has priority, so only one flag is set.
- **States:**
  - IDLE: ready.
  - LOAD: `mem_read`=1.
  - RMW_RD: `mem_read`=1.
  - WRITE: `mem_write`=1.
- **Transitions:**
  - load: IDLE → LOAD → IDLE.
  - SW: IDLE → WRITE → IDLE.
  - SB/SH: IDLE → RMW_RD → WRITE → IDLE.
- **Load extraction in LOAD:**
  - LB/LBU: byte lane `addr[1:0]`, i.e. bits `[8*k+7:8*k]`.
  - LH/LHU: halfword lane `addr[1]`.
  - LB/LH are sign-extended; LBU/LHU are zero-extended; LW is passed through.
  - The result is registered into `rsp_rdata`.
- **Store merge in RMW_RD:**
  - `read_data` is captured with the target lane replaced: `wdata[7:0]` for SB, `wdata[15:0]` for SH. Other lanes are preserved.
  - The merged word is held in a register and driven on `write_data` in WRITE.
  - SW drives the latched wdata directly.
- **Idle outputs:** `mem_read`/`mem_write` are 0 outside their states. `write_data` is 0 outside WRITE. `mem_addr` holds the last latched aligned address.

## Timing
- **Reset values:**
  - state IDLE, `req_ready`=1;
  - `rsp_valid`, `rsp_rdata`, `rsp_misaligned`, `rsp_fault` = 0;
  - `mem_read`, `mem_write`, `mem_addr`, `write_data` = 0.
- **Latency (acceptance edge = cycle 0):**
  - load: LOAD in cycle 1, `rsp_valid` in cycle 2;
  - SW: WRITE in cycle 1, `rsp_valid` in cycle 2;
  - SB/SH: RMW_RD in cycle 1, WRITE in cycle 2, `rsp_valid` in cycle 3;
  - error: `rsp_valid` in cycle 1.
- **Response pulse:** `rsp_valid` is high for exactly one cycle. The unit is in IDLE during that cycle, so a new request may be accepted in the same cycle as the response.
- **Busy behaviour:** `req_ready`=0 in LOAD, RMW_RD and WRITE. A held `req_valid` is accepted once, on the first IDLE edge.
- **Reset mid-operation:**
  - `mem_write` and `mem_read` are gated by `!rst`, so no write commits at the reset edge;
  - the in-flight request is dropped with no `rsp_valid`.
- **Memory address:** `mem_addr` is stable for the whole memory-state cycle. The memory sees only word-aligned addresses.

## Test plan
- Word at 0x10 = 0x80007F80:
  - LB 0x10 → 0xFFFFFF80;
  - LBU 0x10 → 0x00000080;
  - LB 0x11 → 0x0000007F;
  - LH 0x12 → 0xFFFF8000;
  - LHU 0x12 → 0x00008000;
  - LW 0x10 → 0x80007F80;
  - each with `rsp_valid` exactly 2 cycles after acceptance.
- Word at 0x20 = 0x11223344:
  - SB 0x21 wdata 0xFFFFFFAB → `mem_write` in cycle 2 with `write_data`=0x1122AB44;
  - SH 0x22 wdata 0x0000BEEF → 0xBEEFAB44;
  - follow-up LW 0x20 returns 0xBEEFAB44.
- SH 0x23, LW 0x22 and SW 0x21 → `rsp_misaligned`=1 in cycle 1, `mem_read`/`mem_write` never asserted, memory unchanged.
- LW 0x1000 → `rsp_fault`=1. Load func3=3 → fault. `req_load`=`req_store`=1 → fault, with `rsp_misaligned`=0 even for an odd address.
- `req_valid` held high through back-to-back LW, SB, LW:
  - `req_ready` low while busy;
  - each request is accepted once;
  - a new request is accepted in the same cycle as the previous `rsp_valid`;
  - responses arrive in order.
- `rst`=1 during the WRITE cycle of SB 0x21 → `mem_write`=0, word unchanged, all outputs at reset values next cycle, no `rsp_valid`.
